// File: rtl/oflow_fe_stream.sv
// oflow_fe_stream: streaming bbox feature extraction for the oflow tracker.
// Two-stage valid/ready pipeline plus per-frame object count and overflow.
module oflow_fe_stream #(
    parameter int COORD_W = 11,
    parameter int COLOR_W = 24,
    parameter int MAX_OBJ = 32,
    parameter int IDX_W   = $clog2(MAX_OBJ),
    parameter int BBOX_W  = 4*COORD_W + 2*COLOR_W
) (
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 fe_enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BBOX_W-1:0]    in_bbox,
    input  logic                 in_sof,
    input  logic                 in_eof,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*COORD_W-1:0] out_cm_concate,
    output logic [2*COORD_W-1:0] out_position_concate,
    output logic [COORD_W-1:0]   out_width,
    output logic [COORD_W-1:0]   out_height,
    output logic [COLOR_W-1:0]   out_color1,
    output logic [COLOR_W-1:0]   out_color2,
    output logic [IDX_W-1:0]     out_obj_idx,
    output logic                 out_bad_bbox,
    output logic                 frame_done,
    output logic [IDX_W:0]       frame_obj_count,
    output logic                 frame_overflow
);

    localparam logic [IDX_W:0] CNT_ONE = {{IDX_W{1'b0}}, 1'b1};

    logic [COORD_W-1:0] w_xmin, w_ymin, w_xmax, w_ymax;
    logic [COLOR_W-1:0] w_c1, w_c2;
    logic               w_s1_adv, w_acc, w_keep, w_bad;
    logic [IDX_W:0]     w_idx, w_cnt_nxt;
    logic               w_ovf_nxt;

    logic               r_s1_valid, r_s2_valid;
    logic [COORD_W-1:0] r_s1_xmin, r_s1_ymin, r_s1_xmax, r_s1_ymax;
    logic [COORD_W:0]   r_s1_sx, r_s1_sy;
    logic [COLOR_W-1:0] r_s1_c1, r_s1_c2;
    logic [IDX_W-1:0]   r_s1_idx;
    logic [IDX_W:0]     r_count;
    logic               r_ovf;

    assign w_xmin = in_bbox[COORD_W-1:0];
    assign w_ymin = in_bbox[2*COORD_W-1:COORD_W];
    assign w_xmax = in_bbox[3*COORD_W-1:2*COORD_W];
    assign w_ymax = in_bbox[4*COORD_W-1:3*COORD_W];
    assign w_c1   = in_bbox[4*COORD_W+COLOR_W-1:4*COORD_W];
    assign w_c2   = in_bbox[4*COORD_W+2*COLOR_W-1:4*COORD_W+COLOR_W];

    assign w_s1_adv = !r_s2_valid || out_ready;
    assign in_ready = reset_N && fe_enable && (!r_s1_valid || w_s1_adv);
    assign w_acc    = in_valid && in_ready;

    // Count saturates at MAX_OBJ, so its top bit marks a beat to drop.
    assign w_idx     = in_sof ? '0 : r_count;
    assign w_keep    = !w_idx[IDX_W];
    assign w_cnt_nxt = w_keep ? w_idx + CNT_ONE : w_idx;
    assign w_ovf_nxt = (in_sof ? 1'b0 : r_ovf) | !w_keep;

    assign w_bad = (r_s1_xmax < r_s1_xmin) || (r_s1_ymax < r_s1_ymin);

    // Frame bookkeeping: running index, overflow and end-of-frame report.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_count         <= '0;
            r_ovf           <= 1'b0;
            frame_done      <= 1'b0;
            frame_obj_count <= '0;
            frame_overflow  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_acc && in_eof) begin
                frame_done      <= 1'b1;
                frame_obj_count <= w_cnt_nxt;
                frame_overflow  <= w_ovf_nxt;
                r_count         <= '0;
                r_ovf           <= 1'b0;
            end else if (w_acc) begin
                r_count <= w_cnt_nxt;
                r_ovf   <= w_ovf_nxt;
            end
        end
    end

    // Stage 1: capture kept beats and pre-add the coordinate pairs.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_s1_valid <= 1'b0;
            r_s1_xmin  <= '0;
            r_s1_ymin  <= '0;
            r_s1_xmax  <= '0;
            r_s1_ymax  <= '0;
            r_s1_sx    <= '0;
            r_s1_sy    <= '0;
            r_s1_c1    <= '0;
            r_s1_c2    <= '0;
            r_s1_idx   <= '0;
        end else if (w_acc) begin
            r_s1_valid <= w_keep;
            if (w_keep) begin
                r_s1_xmin <= w_xmin;
                r_s1_ymin <= w_ymin;
                r_s1_xmax <= w_xmax;
                r_s1_ymax <= w_ymax;
                r_s1_sx   <= {1'b0, w_xmin} + {1'b0, w_xmax};
                r_s1_sy   <= {1'b0, w_ymin} + {1'b0, w_ymax};
                r_s1_c1   <= w_c1;
                r_s1_c2   <= w_c2;
                r_s1_idx  <= w_idx[IDX_W-1:0];
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_s2_valid           <= 1'b0;
            out_cm_concate       <= '0;
            out_position_concate <= '0;
            out_width            <= '0;
            out_height           <= '0;
            out_color1           <= '0;
            out_color2           <= '0;
            out_obj_idx          <= '0;
            out_bad_bbox         <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_position_concate <= {r_s1_xmin, r_s1_ymin};
                out_color1           <= r_s1_c1;
                out_color2           <= r_s1_c2;
                out_obj_idx          <= r_s1_idx;
                out_bad_bbox         <= w_bad;
                if (w_bad) begin
                    out_cm_concate <= {r_s1_xmin, r_s1_ymin};
                    out_width      <= '0;
                    out_height     <= '0;
                end else begin
                    out_cm_concate <= {COORD_W'(r_s1_sx >> 1),
                                       COORD_W'(r_s1_sy >> 1)};
                    out_width      <= r_s1_xmax - r_s1_xmin;
                    out_height     <= r_s1_ymax - r_s1_ymin;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;

endmodule
